// File: rtl/mem.sv
// Memory-access pipeline stage: registers the dc-to-mem bus, collects SRAM load data,
// aligns/extends it and drives the writeback and forwarding buses.
module mem #(
    parameter int DC_TO_MEM_WD = 145,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_RF_WD = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [6:0]              stall,
    input  logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
    input  logic                    data_sram_data_ok,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic                    stallreq_for_load
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DONE    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    logic [DC_TO_MEM_WD-1:0] bus_d, bus_q;
    state_e                  state_d, state_q;
    logic [31:0]             rdata_buf_d, rdata_buf_q;

    logic [2:0]  ld_type;
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        is_load;
    logic        rdata_use;
    logic [31:0] load_word;
    logic [31:0] rf_wdata;

    function automatic logic [31:0] align_load(input logic [2:0]  lt,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (lt)
            3'b001:  return {{24{b[7]}}, b};
            3'b010:  return {24'h0, b};
            3'b011:  return {{16{h[15]}}, h};
            3'b100:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign ld_type      = bus_q[144:142];
    assign hilo_bus     = bus_q[141:76];
    assign pc           = bus_q[75:44];
    assign data_ram_en  = bus_q[43];
    assign data_ram_wen = bus_q[42:39];
    assign sel_rf_res   = bus_q[38];
    assign rf_we        = bus_q[37];
    assign rf_waddr     = bus_q[36:32];
    assign alu_result   = bus_q[31:0];
    assign is_load      = data_ram_en && (data_ram_wen == 4'b0000);

    always_comb begin
        bus_d = bus_q;
        if (flush) begin
            bus_d = '0;
        end else if (stall[5] && !stall[6]) begin
            bus_d = '0;
        end else if (!stall[5]) begin
            bus_d = dc_to_mem_bus;
        end
    end

    // Response tracking: DISCARD swallows the reply to a load that was flushed mid-flight.
    always_comb begin
        state_d           = state_q;
        rdata_buf_d       = rdata_buf_q;
        stallreq_for_load = 1'b0;
        rdata_use         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_load) begin
                    if (data_sram_data_ok) begin
                        rdata_use = 1'b1;
                        if (!flush && stall[5]) begin
                            rdata_buf_d = data_sram_rdata;
                            state_d     = S_DONE;
                        end
                    end else begin
                        stallreq_for_load = 1'b1;
                        state_d           = flush ? S_DISCARD : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    rdata_use = is_load;
                    if (!flush && stall[5] && is_load) begin
                        rdata_buf_d = data_sram_rdata;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stallreq_for_load = is_load;
                    if (flush) begin
                        state_d = S_DISCARD;
                    end
                end
            end
            S_DONE: begin
                if (!stall[5] || flush) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                stallreq_for_load = is_load;
                if (data_sram_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q       <= '0;
            state_q     <= S_IDLE;
            rdata_buf_q <= '0;
        end else begin
            bus_q       <= bus_d;
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    always_comb begin
        if (state_q == S_DONE) begin
            load_word = rdata_buf_q;
        end else if (rdata_use) begin
            load_word = data_sram_rdata;
        end else begin
            load_word = 32'h0;
        end
        rf_wdata = sel_rf_res ? align_load(ld_type, alu_result[1:0], load_word) : alu_result;
    end

    assign mem_to_wb_bus = {hilo_bus, pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Memory-access pipeline stage directly downstream of the dc stage.
- Registers the dc-to-mem bus under stall/flush control and collects load data from the data SRAM response channel.
- Aligns and extends load data, selects the register-file write value, and drives the mem-to-wb bus and the mem forwarding bus.
- Requests a pipeline stall while a resident load's data has not arrived.

Parameters:
DC_TO_MEM_WD, 145, input bus width: {ld_type[2:0] 144:142, hilo_bus 141:76, pc 75:44, data_ram_en 43, data_ram_wen 42:39, sel_rf_res 38, rf_we 37, rf_waddr 36:32, alu_result 31:0}
MEM_TO_WB_WD, 136, output bus width: {hilo_bus 135:70, pc 69:38, rf_we 37, rf_waddr 36:32, rf_wdata 31:0}
MEM_TO_RF_WD, 38, forwarding bus width: {rf_we 37, rf_waddr 36:32, rf_wdata 31:0}

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
flush  input  1  exception/redirect flush, synchronous
stall  input  StallBus  pipeline stall vector; this stage uses bit 5 (own) and bit 6 (downstream); Stop=1
dc_to_mem_bus  input  DC_TO_MEM_WD  from dc stage
data_sram_data_ok  input  1  one-cycle pulse, read response valid
data_sram_rdata  input  32  read data, valid with data_ok
mem_to_wb_bus  output  MEM_TO_WB_WD  to wb stage
mem_to_rf_bus  output  MEM_TO_RF_WD  forwarding to id stage
stallreq_for_load  output  1  stall request to the stall controller

Behaviour:
- Stage register, priority order:
  - rst=0: clear all fields.
  - Else flush: clear all fields.
  - Else stall[5]=1 and stall[6]=0: load a bubble (all zero).
  - Else stall[5]=0: capture dc_to_mem_bus.
  - Else: hold.
- Resident load: data_ram_en=1 and data_ram_wen=4'b0. Stores and non-memory ops never stall.
- ld_type encoding: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu. Other codes are treated as lw.
- Byte lanes are little-endian; offset = alu_result[1:0].
  - lb/lbu select byte [8*off+7:8*off].
  - lh/lhu select half [16*off[1]+15:16*off[1]].
  - Sign- or zero-extend to 32 bits. Misalignment is never seen (trapped upstream).
- rf_wdata = sel_rf_res ? aligned load data : alu_result.
- Outputs are combinational from the stage register plus the response/buffer; no added latency. mem_to_rf_bus mirrors the rf fields of mem_to_wb_bus.
- FSM, 2-bit state, reset to IDLE:
  - IDLE:
    - Resident load and data_ok=1: use data_sram_rdata this cycle, stallreq=0. If stall[5]=1, latch into rdata_buf and go DONE.
    - Resident load and data_ok=0: stallreq=1, go WAIT.
  - WAIT:
    - stallreq = ~data_ok.
    - On data_ok: use data_sram_rdata. If stall[5]=1, latch rdata_buf and go DONE; else go IDLE.
    - flush without data_ok: go DISCARD. Flush with data_ok: go IDLE.
  - DONE:
    - Load data is taken from rdata_buf; stallreq=0.
    - Return to IDLE when stall[5]=0 (register advances) or flush.
  - DISCARD:
    - Ignore the next data_ok (do not write rdata_buf), then go IDLE.
    - While in DISCARD with a new resident load, stallreq=1 and that data_ok must not be used as the new load's data.
    - A response arriving in the IDLE cycle following DISCARD belongs to the new load.
- Boundary cases:
  - data_ok in the same cycle the load enters IDLE is valid.
  - A data_ok with no resident load and no DISCARD is ignored.
  - Reset mid-WAIT: state returns to IDLE, rdata_buf is cleared, outputs are zero.
  - A bubble or flushed slot always drives rf_we=0, stallreq=0.
- Reset values: mem_to_wb_bus=0, mem_to_rf_bus=0, stallreq_for_load=0, rdata_buf=0.

Test Plan:
- Non-memory pass-through: alu_result=32'h1234_5678, rf_we=1, waddr=5, sel_rf_res=0 → the next cycle mem_to_wb_bus carries wdata 32'h1234_5678, we=1, waddr=5; stallreq stays 0.
- Load extension:
  - rdata=32'h80FF_7F01, lb with offset 3 → wdata 32'hFFFF_FF80.
  - lbu with offset 1 → 32'h0000_007F.
  - lh with offset 2 → 32'hFFFF_80FF.
  - lhu with offset 0 → 32'h0000_7F01.
  - lw → 32'h80FF_7F01.
- Delayed response: lw resident with data_ok 3 cycles late → stallreq=1 for exactly 3 cycles, deasserts in the data_ok cycle, and wdata equals rdata in that cycle.
- Downstream hold: data_ok arrives while stall[5]=1 with rdata=32'hCAFE_0001; rdata changes afterwards → output stays 32'hCAFE_0001 until stall[5]=0, then the FSM is in IDLE.
- Flush while waiting: flush in WAIT, then a new lw enters, then a stale data_ok (32'hDEAD), then a fresh data_ok (32'hBEEF) → 32'hDEAD is never on rf_wdata; the new load completes with 32'hBEEF; stallreq=1 until the fresh data_ok.
- Async reset: drive rst=0 mid-WAIT between clock edges → outputs go to zero immediately, stallreq=0, FSM is in IDLE after rst returns to 1.
